prom_loader: RTL and testbench
==============================

PROM_LOADER -- requirements
Module: prom_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 1024, meaning the number of PROM words copied per run, legal range 1..1024.
REQ-002 The block SHALL have parameter DEST_BASE, default 32'h0000_0000, meaning the byte address written for PROM word 0.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a copy run.
REQ-006 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-007 The block SHALL have port done  output  1  one-cycle pulse when the last word is accepted.
REQ-008 The block SHALL have port prom_ce  output  1  PROM read enable.
REQ-009 The block SHALL have port prom_adr  output  10  PROM word address.
REQ-010 The block SHALL have port prom_data  input  32  PROM registered read data, valid the cycle after prom_ce, held while prom_ce low.
REQ-011 The block SHALL have port wr_valid  output  1  write request to the destination memory.
REQ-012 The block SHALL have port wr_ready  input  1  destination accepts the write in this cycle when high with wr_valid.
REQ-013 The block SHALL have port wr_adr  output  32  destination byte address.
REQ-014 The block SHALL have port wr_data  output  32  destination write data.

Function
REQ-015 The block SHALL implement states IDLE, READ, WRITE, DONE, held in a registered state variable.
REQ-016 IDLE: busy=0, prom_ce=0, wr_valid=0; start=1 SHALL clear word index idx to 0 and move to READ next cycle.
REQ-017 READ: prom_ce=1, prom_adr=idx[9:0], wr_valid=0, busy=1; the state SHALL unconditionally move to WRITE next cycle.
REQ-018 WRITE: prom_ce=0, wr_valid=1, wr_data=prom_data combinationally, wr_adr=DEST_BASE+4*idx, busy=1.
REQ-019 In WRITE, wr_valid, wr_adr and wr_data SHALL stay stable until wr_ready=1; wr_valid SHALL never drop before acceptance.
REQ-020 In WRITE with wr_ready=1 and idx<WORDS-1, the block SHALL increment idx and move to READ.
REQ-021 In WRITE with wr_ready=1 and idx=WORDS-1, the block SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, busy=1, wr_valid=0, prom_ce=0, then return to IDLE.
REQ-023 Per-word latency SHALL be 2 cycles minimum (READ+WRITE); a full run with wr_ready tied high SHALL take 2*WORDS+1 cycles from the cycle after start through DONE.
REQ-024 wr_adr arithmetic SHALL be 32-bit modulo 2^32; DEST_BASE+4*idx wrapping past 32'hFFFF_FFFC SHALL wrap silently.
REQ-025 idx SHALL be 11 bits wide so WORDS=1024 terminates at idx=1023 without overflow.
REQ-026 start SHALL be ignored in every state except IDLE, including DONE.
REQ-027 prom_ce SHALL be high only in READ; prom_adr SHALL equal idx[9:0] in all states.
REQ-028 wr_ready while wr_valid=0 SHALL have no effect.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE and idx=0, overriding all other inputs, including start asserted in the same cycle.
REQ-030 After reset, outputs SHALL be busy=0, done=0, prom_ce=0, prom_adr=0, wr_valid=0, wr_adr=DEST_BASE.
REQ-031 Reset during READ or WRITE SHALL abort the run with no further write issued and no done pulse.

Verification
REQ-032 WORDS=4, DEST_BASE=32'h100, PROM holds A0..A3, wr_ready=1, start pulse -> writes (100,A0),(104,A1),(108,A2),(10C,A3) on consecutive even cycles; done pulse 9 cycles after start; busy falls the following cycle.
REQ-033 wr_ready held low 5 cycles during word 1 -> wr_valid/wr_adr/wr_data are stable for all 5 cycles, prom_ce stays 0, and the word is accepted once on the first high cycle.
REQ-034 start re-pulsed while busy and in the DONE cycle -> ignored; exactly one run, 4 writes; a start after return to IDLE begins a new run from idx 0.
REQ-035 rst asserted during WRITE of word 2 -> next cycle wr_valid=0, busy=0, no done; a new start copies from word 0.
REQ-036 WORDS=1024, DEST_BASE=32'hFFFF_FFF8 -> last prom_adr=1023, wr_adr wraps 32'hFFFF_FFFC -> 32'h0000_0000, done is asserted once, 2049 cycles after start.

Source files
------------

// File: rtl/prom_loader.sv
// Copies WORDS PROM words to DEST_BASE+4*idx: READ then WRITE per word, 2 cycles/word minimum, 2*WORDS+1 per run.
// Backpressure: wr_valid/wr_adr/wr_data hold in WRITE until wr_ready; start is ignored unless idle.
module prom_loader #(
    parameter int          WORDS     = 1024,
    parameter logic [31:0] DEST_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        prom_ce,
    output logic [9:0]  prom_adr,
    input  logic [31:0] prom_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_adr,
    output logic [31:0] wr_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [10:0] LAST = 11'(WORDS - 1);

    state_t      state;
    logic [10:0] idx;

    // Outputs are registered alongside the state so they change only on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            prom_ce  <= 1'b0;
            wr_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        state   <= READ;
                        busy    <= 1'b1;
                        prom_ce <= 1'b1;
                    end
                end
                READ: begin
                    state    <= WRITE;
                    prom_ce  <= 1'b0;
                    wr_valid <= 1'b1;
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (idx == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            idx     <= idx + 11'd1;
                            state   <= READ;
                            prom_ce <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign prom_adr = idx[9:0];
    // 32-bit add wraps modulo 2^32 past the top of the address space.
    assign wr_adr   = DEST_BASE + {19'b0, idx, 2'b00};
    assign wr_data  = prom_data;

endmodule

// File: tb/tb_prom_loader.sv
// Scoreboard bench: stimulus pushes expected writes/done cycles/probes; one negedge monitor compares.
module tb_prom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        prom_ce  [2];
    logic [9:0]  prom_adr [2];
    logic [31:0] prom_data[2];
    logic        wr_valid [2];
    logic        wr_ready [2];
    logic [31:0] wr_adr   [2];
    logic [31:0] wr_data  [2];

    always #5 clk = ~clk;

    prom_loader #(.WORDS(4), .DEST_BASE(32'h0000_0100)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .prom_ce(prom_ce[0]), .prom_adr(prom_adr[0]), .prom_data(prom_data[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_adr(wr_adr[0]), .wr_data(wr_data[0])
    );

    prom_loader #(.WORDS(1024), .DEST_BASE(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .prom_ce(prom_ce[1]), .prom_adr(prom_adr[1]), .prom_data(prom_data[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_adr(wr_adr[1]), .wr_data(wr_data[1])
    );

    // PROM model: registered read, data held while prom_ce is low.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (prom_ce[0]) prom_data[0] <= mem[prom_adr[0]];
        if (prom_ce[1]) prom_data[1] <= mem[prom_adr[1]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] adr; logic [31:0] dat; } wr_t;
    typedef struct { int cyc; int d; int sel; logic [31:0] exp; } probe_t;

    wr_t    exp_q  [2][$];
    int     done_q [2][$];
    probe_t probes [$];
    int     n_cmp = 0;
    int     n_fail = 0;
    bit     finish_req = 1'b0;

    function automatic int nw(int d);
        return (d == 0) ? 4 : 1024;
    endfunction

    function automatic logic [31:0] base(int d);
        return (d == 0) ? 32'h0000_0100 : 32'hFFFF_FFF8;
    endfunction

    function automatic logic [31:0] sig(int d, int s);
        case (s)
            0:       return 32'(busy[d]);
            1:       return 32'(done[d]);
            2:       return 32'(prom_ce[d]);
            3:       return 32'(prom_adr[d]);
            4:       return 32'(wr_valid[d]);
            5:       return wr_adr[d];
            default: return wr_data[d];
        endcase
    endfunction

    function automatic string sname(int s);
        case (s)
            0:       return "busy";
            1:       return "done";
            2:       return "prom_ce";
            3:       return "prom_adr";
            4:       return "wr_valid";
            5:       return "wr_adr";
            default: return "wr_data";
        endcase
    endfunction

    // ---------------- monitor / scoreboard (sole owner of the counters) ----------------
    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && wr_valid[d] && wr_ready[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write dut%0d cyc=%0d actual adr=%h data=%h required none",
                             d, cyc, wr_adr[d], wr_data[d]);
                end else begin
                    wr_t e;
                    e = exp_q[d].pop_front();
                    chk("wr_adr", d, wr_adr[d], e.adr);
                    chk("wr_data", d, wr_data[d], e.dat);
                    if (e.cyc >= 0) chk("wr_cycle", d, 32'(cyc), 32'(e.cyc));
                end
            end
            if (done[d]) begin
                if (done_q[d].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done dut%0d cyc=%0d actual=1 required=0", d, cyc);
                end else begin
                    int dc;
                    dc = done_q[d].pop_front();
                    if (dc >= 0) chk("done_cycle", d, 32'(cyc), 32'(dc));
                    chk("writes_left_at_done", d, 32'(exp_q[d].size()), 32'd0);
                end
            end
        end
        for (int i = probes.size() - 1; i >= 0; i--) begin
            if (probes[i].cyc == cyc) begin
                chk(sname(probes[i].sel), probes[i].d, sig(probes[i].d, probes[i].sel), probes[i].exp);
                probes.delete(i);
            end
        end
        if (finish_req) begin
            for (int d = 0; d < 2; d++) begin
                chk("writes_outstanding", d, 32'(exp_q[d].size()), 32'd0);
                chk("done_outstanding", d, 32'(done_q[d].size()), 32'd0);
            end
            chk("probes_unreached", 0, 32'(probes.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus and reference model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) tick();
    endtask

    task automatic probe(int c, int d, int sel, logic [31:0] e);
        probe_t p;
        p.cyc = c; p.d = d; p.sel = sel; p.exp = e;
        probes.push_back(p);
    endtask

    // A run whose start is driven in region c0: word i lands 2*(i+1) cycles later, plus any stall.
    task automatic issue_run(int d, int c0, int stall_at, int stall_len, bit rnd);
        for (int i = 0; i < nw(d); i++) begin
            wr_t e;
            e.cyc = rnd ? -1 : c0 + 2 + 2 * i + ((i >= stall_at) ? stall_len : 0);
            e.adr = base(d) + 32'(4 * i);
            e.dat = mem[i];
            exp_q[d].push_back(e);
        end
        if (rnd) begin
            done_q[d].push_back(-1);
        end else begin
            done_q[d].push_back(c0 + 2 * nw(d) + 1 + stall_len);
            probe(c0 + 2 * nw(d) + 2 + stall_len, d, 0, 32'd0);
        end
    endtask

    int c;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1;
        start[0] = 1'b0;  start[1] = 1'b0;
        wr_ready[0] = 1'b1; wr_ready[1] = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 5; s++) probe(3, d, s, 32'd0);
            probe(3, d, 5, base(d));
        end
        tick();
        tick();
        start[0] = 1'b1;            // start together with reset must be overridden
        tick();
        rst = 1'b0;
        start[0] = 1'b0;
        tick();

        // Basic run, wr_ready tied high
        c = cyc;
        start[0] = 1'b1;
        issue_run(0, c, 99, 0, 1'b0);
        probe(c + 1, 0, 0, 32'd1);
        probe(c + 1, 0, 2, 32'd1);
        probe(c + 2, 0, 2, 32'd0);
        probe(c + 2, 0, 4, 32'd1);
        probe(c + 3, 0, 3, 32'd1);
        probe(c + 9, 0, 0, 32'd1);
        probe(c + 9, 0, 2, 32'd0);
        probe(c + 9, 0, 4, 32'd0);
        tick();
        start[0] = 1'b0;
        wait_until(c + 12);

        // Five-cycle stall on word 1
        c = cyc;
        for (int k = 4; k <= 8; k++) begin
            probe(c + k, 0, 4, 32'd1);
            probe(c + k, 0, 5, 32'h0000_0104);
            probe(c + k, 0, 6, mem[1]);
            probe(c + k, 0, 2, 32'd0);
        end
        start[0] = 1'b1;
        issue_run(0, c, 1, 5, 1'b0);
        tick();
        start[0] = 1'b0;
        while (cyc < c + 17) begin
            wr_ready[0] = !(cyc >= c + 4 && cyc <= c + 8);
            tick();
        end
        wr_ready[0] = 1'b1;

        // Start re-pulsed while busy and during DONE is ignored; a later start runs again
        c = cyc;
        start[0] = 1'b1;
        issue_run(0, c, 99, 0, 1'b0);
        tick();
        while (cyc < c + 10) begin
            start[0] = (cyc == c + 3 || cyc == c + 6 || cyc == c + 9);
            tick();
        end
        start[0] = 1'b0;
        tick();
        c = cyc;
        start[0] = 1'b1;
        issue_run(0, c, 99, 0, 1'b0);
        tick();
        start[0] = 1'b0;
        wait_until(c + 12);

        // Reset during WRITE of word 2 aborts the run
        c = cyc;
        start[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_t e;
            e.cyc = c + 2 + 2 * i;
            e.adr = 32'h0000_0100 + 32'(4 * i);
            e.dat = mem[i];
            exp_q[0].push_back(e);
        end
        probe(c + 6, 0, 4, 32'd1);
        probe(c + 7, 0, 4, 32'd0);
        probe(c + 7, 0, 0, 32'd0);
        probe(c + 7, 0, 1, 32'd0);
        probe(c + 7, 0, 3, 32'd0);
        tick();
        start[0] = 1'b0;
        wait_until(c + 6);
        rst = 1'b1;
        wr_ready[0] = 1'b0;
        tick();
        rst = 1'b0;
        wr_ready[0] = 1'b1;
        tick();
        c = cyc;
        start[0] = 1'b1;
        issue_run(0, c, 99, 0, 1'b0);
        tick();
        start[0] = 1'b0;
        wait_until(c + 12);

        // Randomised runs: fresh PROM words, random wr_ready, stray start pulses
        repeat (8) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int i = 0; i < 4; i++) mem[i] = $urandom;
            c = cyc;
            start[0] = 1'b1;
            issue_run(0, c, 99, 0, 1'b1);
            tick();
            for (int n = 0; n < 300; n++) begin
                bit saw;
                saw = done[0];
                start[0] = ($urandom_range(0, 7) == 0);
                wr_ready[0] = ($urandom_range(0, 99) < 65);
                tick();
                if (saw) break;
            end
            start[0] = 1'b0;
            wr_ready[0] = 1'b1;
        end
        repeat (3) tick();

        // Full 1024-word run with address wrap
        c = cyc;
        start[1] = 1'b1;
        issue_run(1, c, 99, 0, 1'b0);
        probe(c + 2047, 1, 3, 32'd1023);
        probe(c + 2047, 1, 2, 32'd1);
        probe(c + 4, 1, 5, 32'hFFFF_FFFC);
        probe(c + 6, 1, 5, 32'h0000_0000);
        tick();
        start[1] = 1'b0;
        wait_until(c + 2053);

        finish_req = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor_finish actual=still_running required=finished");
        $fatal(1);
    end

endmodule
